// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU / video) arbiter in front of a banked memory with a 2-stage read pipeline.
// mem_rdata is sampled at the end of the command cycle, so rvalid arrives 2 cycles after grant.
module mem_bus_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_BANKS = 3,
  parameter int unsigned VID_BANK  = 2,
  parameter int unsigned MODE      = 0,
  localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [BANK_W-1:0]           cpu_bank,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  input  logic                        cpu_done,
  output logic                        cpu_gnt,
  output logic                        cpu_rvalid,
  output logic [DATA_W-1:0]           cpu_rdata,
  input  logic                        vid_en,
  input  logic                        vid_req,
  input  logic [ADDR_W-1:0]           vid_addr,
  output logic                        vid_gnt,
  output logic                        vid_rvalid,
  output logic [DATA_W-1:0]           vid_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [NUM_BANKS-1:0]        mem_we,
  input  logic [NUM_BANKS*DATA_W-1:0] mem_rdata,
  output logic                        finished
);

  logic                 finished_q;
  logic                 rr_q, rr_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [NUM_BANKS-1:0] mem_we_q, mem_we_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_vid_q, s1_vid_d;
  logic [BANK_W-1:0]    s1_bank_q, s1_bank_d;
  logic                 cpu_rvalid_q, cpu_rvalid_d;
  logic                 vid_rvalid_q, vid_rvalid_d;
  logic [DATA_W-1:0]    cpu_rdata_q, vid_rdata_q;
  logic [DATA_W-1:0]    rd_sel;
  logic                 cpu_elig, vid_elig, cpu_r, vid_r;

  always_comb begin
    if (MODE == 0) begin
      cpu_elig = ~finished_q;
      vid_elig = finished_q & vid_en;
    end else begin
      cpu_elig = 1'b1;
      vid_elig = vid_en;
    end
    cpu_r = reset & cpu_req & cpu_elig;
    vid_r = reset & vid_req & vid_elig;
    // rr_q = 1 means the CPU won last, so video wins the next conflict
    cpu_gnt = cpu_r & (~vid_r | ~rr_q);
    vid_gnt = vid_r & ~cpu_gnt;
  end

  always_comb begin
    rr_d        = rr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = '0;
    s1_valid_d  = 1'b0;
    s1_vid_d    = s1_vid_q;
    s1_bank_d   = s1_bank_q;
    if (cpu_gnt) begin
      rr_d        = 1'b1;
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
      s1_valid_d  = ~cpu_we;
      s1_vid_d    = 1'b0;
      s1_bank_d   = cpu_bank;
      if (cpu_we) begin
        // Out-of-range banks match no k and so raise no write enable
        for (int k = 0; k < int'(NUM_BANKS); k++) begin
          mem_we_d[k] = (cpu_bank == BANK_W'(k));
        end
      end
    end else if (vid_gnt) begin
      rr_d       = 1'b0;
      mem_addr_d = vid_addr;
      s1_valid_d = 1'b1;
      s1_vid_d   = 1'b1;
      s1_bank_d  = BANK_W'(VID_BANK);
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < int'(NUM_BANKS); k++) begin
      if (s1_bank_q == BANK_W'(k)) rd_sel = mem_rdata[k*DATA_W +: DATA_W];
    end
    cpu_rvalid_d = s1_valid_q & ~s1_vid_q;
    vid_rvalid_d = s1_valid_q & s1_vid_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      finished_q   <= 1'b0;
      rr_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_vid_q     <= 1'b0;
      s1_bank_q    <= '0;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      vid_rdata_q  <= '0;
    end else begin
      finished_q   <= finished_q | cpu_done;
      rr_q         <= rr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      s1_valid_q   <= s1_valid_d;
      s1_vid_q     <= s1_vid_d;
      s1_bank_q    <= s1_bank_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_rvalid_q <= vid_rvalid_d;
      if (cpu_rvalid_d) cpu_rdata_q <= rd_sel;
      if (vid_rvalid_d) vid_rdata_q <= rd_sel;
    end
  end

  assign finished   = finished_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign vid_rvalid = vid_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign vid_rdata  = vid_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: m0 is the exclusive-handover instance, m1 the round-robin one; inputs are shared.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_done, vid_en, vid_req;
  logic [1:0]  cpu_bank;
  logic [31:0] cpu_addr, cpu_wdata, vid_addr;
  logic [95:0] mem_rdata;

  logic        m0_cpu_gnt, m0_cpu_rvalid, m0_vid_gnt, m0_vid_rvalid, m0_finished;
  logic [31:0] m0_cpu_rdata, m0_vid_rdata, m0_mem_addr, m0_mem_wdata;
  logic [2:0]  m0_mem_we;
  logic        m1_cpu_gnt, m1_cpu_rvalid, m1_vid_gnt, m1_vid_rvalid, m1_finished;
  logic [31:0] m1_cpu_rdata, m1_vid_rdata, m1_mem_addr, m1_mem_wdata;
  logic [2:0]  m1_mem_we;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MODE(0)) m0 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bank(cpu_bank),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_gnt(m0_cpu_gnt),
    .cpu_rvalid(m0_cpu_rvalid), .cpu_rdata(m0_cpu_rdata), .vid_en(vid_en), .vid_req(vid_req),
    .vid_addr(vid_addr), .vid_gnt(m0_vid_gnt), .vid_rvalid(m0_vid_rvalid),
    .vid_rdata(m0_vid_rdata), .mem_addr(m0_mem_addr), .mem_wdata(m0_mem_wdata),
    .mem_we(m0_mem_we), .mem_rdata(mem_rdata), .finished(m0_finished)
  );

  mem_bus_arbiter #(.MODE(1)) m1 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bank(cpu_bank),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_gnt(m1_cpu_gnt),
    .cpu_rvalid(m1_cpu_rvalid), .cpu_rdata(m1_cpu_rdata), .vid_en(vid_en), .vid_req(vid_req),
    .vid_addr(vid_addr), .vid_gnt(m1_vid_gnt), .vid_rvalid(m1_vid_rvalid),
    .vid_rdata(m1_vid_rdata), .mem_addr(m1_mem_addr), .mem_wdata(m1_mem_wdata),
    .mem_we(m1_mem_we), .mem_rdata(mem_rdata), .finished(m1_finished)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_done = 1'b0; vid_en = 1'b0;
    vid_req = 1'b0; cpu_bank = 2'd0; cpu_addr = '0; cpu_wdata = '0; vid_addr = '0;
    mem_rdata = {32'hC2C2_C2C2, 32'hDEAD_BEEF, 32'hA0A0_A0A0};

    // Reset values; a request during reset is not granted
    tick();
    cpu_req = 1'b1;
    #1;
    chk("rst_gnt", 32'(m0_cpu_gnt), 32'd0);
    chk("rst_fin", 32'(m0_finished), 32'd0);
    chk("rst_we", 32'(m0_mem_we), 32'd0);
    chk("rst_addr", m0_mem_addr, 32'd0);
    chk("rst_rvalid", 32'(m0_cpu_rvalid), 32'd0);
    chk("rst_rdata", m0_cpu_rdata, 32'd0);
    cpu_req = 1'b0;
    tick();
    reset = 1'b1;

    // CPU write bank 1, accepted on the first edge after release
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_bank = 2'd1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_gnt", 32'(m0_cpu_gnt), 32'd1);
    tick();
    cpu_req = 1'b0;
    chk("wr_we", 32'(m0_mem_we), 32'b010);
    chk("wr_addr", m0_mem_addr, 32'h10);
    chk("wr_wdata", m0_mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("wr_we_clear", 32'(m0_mem_we), 32'd0);
    chk("wr_addr_hold", m0_mem_addr, 32'h10);
    chk("wr_no_rvalid", 32'(m0_cpu_rvalid), 32'd0);

    // CPU read bank 1
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    cpu_req = 1'b0;
    chk("rd_we", 32'(m0_mem_we), 32'd0);
    chk("rd_rvalid_early", 32'(m0_cpu_rvalid), 32'd0);
    tick();
    chk("rd_rvalid", 32'(m0_cpu_rvalid), 32'd1);
    chk("rd_rdata", m0_cpu_rdata, 32'hDEAD_BEEF);
    tick();
    chk("rd_rvalid_drop", 32'(m0_cpu_rvalid), 32'd0);
    chk("rd_rdata_hold", m0_cpu_rdata, 32'hDEAD_BEEF);

    // Read of a non-existent bank returns zero
    cpu_req = 1'b1; cpu_bank = 2'd3; cpu_addr = 32'h20;
    #1;
    chk("bad_gnt", 32'(m0_cpu_gnt), 32'd1);
    tick();
    cpu_req = 1'b0;
    chk("bad_we", 32'(m0_mem_we), 32'd0);
    chk("bad_addr", m0_mem_addr, 32'h20);
    tick();
    chk("bad_rvalid", 32'(m0_cpu_rvalid), 32'd1);
    chk("bad_rdata", m0_cpu_rdata, 32'd0);

    // Handover: video blocked before done; CPU read in the done cycle still completes
    vid_en = 1'b1; vid_req = 1'b1; vid_addr = 32'h40;
    #1;
    chk("pre_vid_gnt", 32'(m0_vid_gnt), 32'd0);
    cpu_req = 1'b1; cpu_bank = 2'd0; cpu_addr = 32'h30; cpu_done = 1'b1;
    #1;
    chk("done_cpu_gnt", 32'(m0_cpu_gnt), 32'd1);
    chk("done_vid_gnt", 32'(m0_vid_gnt), 32'd0);
    chk("done_fin", 32'(m0_finished), 32'd0);
    tick();
    cpu_done = 1'b0;
    chk("post_fin", 32'(m0_finished), 32'd1);
    chk("post_cpu_gnt", 32'(m0_cpu_gnt), 32'd0);
    chk("post_vid_gnt", 32'(m0_vid_gnt), 32'd1);
    chk("post_addr", m0_mem_addr, 32'h30);
    tick();
    chk("vid_addr", m0_mem_addr, 32'h40);
    chk("vid_we", 32'(m0_mem_we), 32'd0);
    chk("handover_rvalid", 32'(m0_cpu_rvalid), 32'd1);
    chk("handover_rdata", m0_cpu_rdata, 32'hA0A0_A0A0);
    chk("post_cpu_gnt2", 32'(m0_cpu_gnt), 32'd0);
    cpu_req = 1'b0; vid_req = 1'b0;
    tick();
    chk("vid_rvalid", 32'(m0_vid_rvalid), 32'd1);
    chk("vid_rdata", m0_vid_rdata, 32'hC2C2_C2C2);
    chk("vid_cpu_rvalid", 32'(m0_cpu_rvalid), 32'd0);
    chk("fin_sticky", 32'(m0_finished), 32'd1);

    // Reset one cycle after a round-robin instance accepts a read
    cpu_req = 1'b1; cpu_addr = 32'h50;
    #1;
    chk("mr_gnt", 32'(m1_cpu_gnt), 32'd1);
    tick();
    cpu_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("mr_rvalid", 32'(m1_cpu_rvalid), 32'd0);
    chk("mr_addr", m1_mem_addr, 32'd0);
    chk("mr_rdata", m1_cpu_rdata, 32'd0);
    chk("mr_fin", 32'(m0_finished), 32'd0);
    chk("mr_vid_rdata", m0_vid_rdata, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("mr_after1", 32'(m1_cpu_rvalid), 32'd0);
    tick();
    chk("mr_after2", 32'(m1_cpu_rvalid), 32'd0);

    // Round-robin: both request for 6 cycles, CPU favoured first
    cpu_bank = 2'd0; cpu_addr = 32'h100; vid_addr = 32'h200; vid_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cpu_req = (i < 6);
      vid_req = (i < 6);
      #1;
      chk($sformatf("rr_cgnt%0d", i), 32'(m1_cpu_gnt), 32'((i < 6) && (i % 2 == 0)));
      chk($sformatf("rr_vgnt%0d", i), 32'(m1_vid_gnt), 32'((i < 6) && (i % 2 == 1)));
      chk($sformatf("rr_crv%0d", i), 32'(m1_cpu_rvalid), 32'((i >= 2) && (i < 8) && (i % 2 == 0)));
      chk($sformatf("rr_vrv%0d", i), 32'(m1_vid_rvalid), 32'((i >= 2) && (i < 8) && (i % 2 == 1)));
      if (i == 3) chk("rr_crdata", m1_cpu_rdata, 32'hA0A0_A0A0);
      if (i == 4) chk("rr_vrdata", m1_vid_rdata, 32'hC2C2_C2C2);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
